imem_fetch_ctrl: RTL and testbench
==================================

# imem_fetch_ctrl

Sequencer that owns the single port of the 128-word instruction memory. After reset it runs a boot-load phase that streams program words into memory from a loader. It then runs the fetch phase: it keeps the PC, reads one instruction per cycle, and presents it to the decode stage. It handles stalls, branch/jump redirects and a sticky halt when the PC leaves the memory range.

## Interface
Parameters:
- ADDR_W, 7, word-address width of instruction memory (DEPTH = 2^ADDR_W words)
- RESET_PC, 32'h0000_0000, byte address fetched first after boot

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- load_valid  in  1  loader presents a program word
- load_data  in  32  program word
- load_done  in  1  loader finished, single-cycle pulse
- load_ready  out  1  controller accepts load words (high only in BOOT)
- mem_addr  out  ADDR_W  word address to instruction memory
- mem_we  out  1  memory write enable
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  combinational read data for mem_addr
- stall  in  1  decode cannot accept; hold fetch outputs
- redirect  in  1  branch/jump taken
- redirect_pc  in  32  byte target; bits [1:0] ignored (treated as 00)
- if_valid  out  1  if_inst/if_pc hold a valid instruction
- if_inst  out  32  fetched instruction (registered)
- if_pc  out  32  byte address of if_inst (registered)
- halted  out  1  PC left memory range; sticky until reset

## Operation
- States: BOOT (reset state), RUN, HALT.
- BOOT:
  - load_ready=1.
  - Each cycle with load_valid=1: mem_we=1, mem_addr=load_cnt, mem_wdata=load_data, load_cnt++.
  - Transitions to RUN, with pc<=RESET_PC, on either:
    - load_done=1, after writing the word if load_valid is also 1 that cycle; or
    - the write of word DEPTH-1, which also drops load_ready from the next cycle.
  - load_done with no words written: go to RUN and leave memory untouched. This allows a preloaded image.
- RUN:
  - mem_we=0, mem_wdata=0, mem_addr=pc[ADDR_W+1:2].
  - Per-cycle priority is redirect > stall > fetch.
  - redirect: pc<=redirect_pc & ~3, if_valid<=0 (one bubble), if_inst/if_pc unchanged.
  - stall (no redirect): pc, if_valid, if_inst and if_pc all held.
  - fetch: the PC is out of range when pc[31:ADDR_W+2]!=0.
    - In range: if_inst<=mem_rdata, if_pc<=pc, if_valid<=1, pc<=pc+4 (32-bit wrap).
    - Out of range: state<=HALT, if_valid<=0, halted<=1.
- HALT:
  - mem_we=0, if_valid=0, halted=1.
  - redirect, stall and load_* are ignored.
  - Only reset exits HALT.
- load_valid/load_done outside BOOT are ignored.
- Reset values: state=BOOT, load_cnt=0, pc=RESET_PC, if_valid=0, if_inst=0, if_pc=0, halted=0, mem_we=0.
  - load_ready=1 while in BOOT, including during reset.
  - Memory contents are not cleared by reset.

## Timing
- Load: word accepted in cycle T is written at the T rising edge; one word per cycle at full throughput.
- load_done sampled at edge T: RUN from T+1, mem_addr=RESET_PC word in T+1, if_valid=1 with that instruction after edge T+1.
- Steady RUN: one instruction per cycle; if_pc increments by 4 per non-stalled cycle.
- Redirect sampled at edge T: if_valid=0 in cycle T+1, if_pc=target and if_valid=1 after edge T+1.
- Redirect and stall in the same cycle: redirect wins.
- Out-of-range fetch at edge T: halted=1 and if_valid=0 from T+1.
- Reset: outputs take reset values asynchronously on assertion, mid-load or mid-run; operation resumes in BOOT on the first edge after deassertion.

## Test plan
- Boot-load and sequential fetch:
  - Stimulus: load 0x20080005, 0x8C090000, 0xAC090004 on consecutive cycles, then load_done.
  - Response: mem_we at addresses 0, 1, 2; then if_pc 0x0/0x4/0x8 with those instructions, one per cycle, if_valid=1.
- Stall:
  - Stimulus: stall high 2 cycles while if_pc=0x4.
  - Response: if_pc=0x4 and if_inst=0x8C090000 held for 2 cycles, then if_pc=0x8.
- Redirect:
  - Stimulus: redirect=1, redirect_pc=0x43, stall=1 in the same cycle.
  - Response: next cycle if_valid=0; following cycle if_pc=0x40, if_inst=mem[16].
- Full load:
  - Stimulus: 128 consecutive load words, no load_done.
  - Response: load_ready low after the 128th write; RUN entered; first fetch if_pc=0x0.
- Halt:
  - Stimulus: redirect to 0x200 (ADDR_W=7).
  - Response: if_valid=0, halted=1; a subsequent redirect to 0x0 is ignored and halted stays 1.
- Reset mid-run:
  - Stimulus: assert reset mid-run, then load_done with zero words.
  - Response: outputs reset immediately, load_ready=1; after load_done, prior memory words are fetched unchanged from 0x0.

Source files
------------

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: sequencer owning the single port of the instruction memory.
//
// After reset it sits in BOOT, streaming loader words into memory at consecutive
// word addresses. On load_done (or once the last word is written) it switches to
// RUN, where it keeps the PC, reads one instruction per cycle and registers it for
// decode. Redirects insert one bubble; stalls freeze the fetch outputs. Fetching
// from outside the memory range parks the controller in HALT until reset.
//
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   load_valid/data/done    loader word stream and end-of-load pulse
//   load_ready              high only while in BOOT
//   mem_addr/we/wdata       memory port (word address, write enable, write data)
//   mem_rdata               combinational read data for mem_addr
//   stall                   decode cannot accept; hold fetch outputs
//   redirect/redirect_pc    taken branch/jump and its byte target
//   if_valid/if_inst/if_pc  registered fetch result for decode
//   halted                  sticky out-of-range indication
module imem_fetch_ctrl #(
  parameter int unsigned ADDR_W   = 7,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  input  logic [31:0]       load_data,
  input  logic              load_done,
  output logic              load_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              stall,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic              if_valid,
  output logic [31:0]       if_inst,
  output logic [31:0]       if_pc,
  output logic              halted
);

  localparam logic [1:0] StBoot = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StHalt = 2'd2;

  localparam logic [31:0] PcAlignMask = 32'hFFFF_FFFC;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] load_cnt_q, load_cnt_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       if_inst_q, if_inst_d;
  logic [31:0]       if_pc_q, if_pc_d;
  logic              if_valid_q, if_valid_d;
  logic              halted_q, halted_d;

  logic load_wr;
  logic load_last;
  logic pc_oob;

  assign load_wr   = (state_q == StBoot) && load_valid;
  // Writing the top word fills memory; boot ends even without load_done.
  assign load_last = load_wr && (load_cnt_q == {ADDR_W{1'b1}});
  // Any PC bit above the word-address field means the fetch falls outside memory.
  assign pc_oob    = |(pc_q >> (ADDR_W + 2));

  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    pc_d       = pc_q;
    if_inst_d  = if_inst_q;
    if_pc_d    = if_pc_q;
    if_valid_d = if_valid_q;
    halted_d   = halted_q;

    case (state_q)
      StBoot: begin
        if (load_wr) begin
          load_cnt_d = load_cnt_q + 1'b1;
        end
        if (load_done || load_last) begin
          state_d = StRun;
          pc_d    = RESET_PC;
        end
      end

      StRun: begin
        if (redirect) begin
          // Target is fetched on the next edge, so decode sees one bubble.
          pc_d       = redirect_pc & PcAlignMask;
          if_valid_d = 1'b0;
        end else if (!stall) begin
          if (pc_oob) begin
            state_d    = StHalt;
            if_valid_d = 1'b0;
            halted_d   = 1'b1;
          end else begin
            if_inst_d  = mem_rdata;
            if_pc_d    = pc_q;
            if_valid_d = 1'b1;
            pc_d       = pc_q + 32'd4;
          end
        end
      end

      StHalt: begin
        if_valid_d = 1'b0;
        halted_d   = 1'b1;
      end

      default: begin
        state_d = StBoot;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StBoot;
      load_cnt_q <= '0;
      pc_q       <= RESET_PC;
      if_inst_q  <= '0;
      if_pc_q    <= '0;
      if_valid_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      pc_q       <= pc_d;
      if_inst_q  <= if_inst_d;
      if_pc_q    <= if_pc_d;
      if_valid_q <= if_valid_d;
      halted_q   <= halted_d;
    end
  end

  always_comb begin
    load_ready = (state_q == StBoot);
    // state_q is already BOOT during reset; gating keeps writes off while it is held.
    mem_we     = load_wr && !reset;
    mem_wdata  = mem_we ? load_data : 32'h0;
    mem_addr   = (state_q == StBoot) ? load_cnt_q : pc_q[ADDR_W+1:2];
  end

  assign if_valid = if_valid_q;
  assign if_inst  = if_inst_q;
  assign if_pc    = if_pc_q;
  assign halted   = halted_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl with a behavioural memory and
// a word-level reference model of the fetch stream.
module tb_imem_fetch_ctrl;

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DEPTH  = 128;

  logic              clk = 1'b0;
  logic              reset;
  logic              load_valid;
  logic [31:0]       load_data;
  logic              load_done;
  logic              load_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              stall;
  logic              redirect;
  logic [31:0]       redirect_pc;
  logic              if_valid;
  logic [31:0]       if_inst;
  logic [31:0]       if_pc;
  logic              halted;

  imem_fetch_ctrl #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_done   (load_done),
    .load_ready  (load_ready),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_valid    (if_valid),
    .if_inst     (if_inst),
    .if_pc       (if_pc),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  // Instruction memory environment.
  logic [31:0] mem [DEPTH];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end
  assign mem_rdata = mem[mem_addr];

  // Reference model state.
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] m_pc, m_inst, m_ifpc;
  bit          m_valid, m_halted;
  int          checks = 0;
  int          errors = 0;

  function automatic void model_reset();
    m_pc = 32'h0; m_inst = 32'h0; m_ifpc = 32'h0; m_valid = 0; m_halted = 0;
  endfunction

  // One clock edge of the fetch phase, from the behavioural rules.
  function automatic void model_edge(bit r, logic [31:0] rpc, bit s);
    if (m_halted) begin
      m_valid = 0;
    end else if (r) begin
      m_pc = rpc & 32'hFFFF_FFFC;
      m_valid = 0;
    end else if (!s) begin
      if (m_pc >= DEPTH * 4) begin
        m_halted = 1;
        m_valid = 0;
      end else begin
        m_inst  = ref_mem[m_pc / 4];
        m_ifpc  = m_pc;
        m_valid = 1;
        m_pc    = m_pc + 32'd4;
      end
    end
  endfunction

  task automatic cycle(input bit r, input logic [31:0] rpc, input bit s);
    redirect = r; redirect_pc = rpc; stall = s;
    @(posedge clk);
    model_edge(r, rpc, s);
    #1;
    redirect = 0; stall = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL rst_load_ready got %b want 1", load_ready); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rst_if_valid got %b want 0", if_valid); end
    checks++; if (if_inst !== 32'h0) begin errors++; $display("FAIL rst_if_inst got %h want 0", if_inst); end
    checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL rst_if_pc got %h want 0", if_pc); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted got %b want 0", halted); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we got %b want 0", mem_we); end
    reset = 0;
    model_reset();
  endtask

  task automatic test_boot_seq();
    logic [31:0] w [3];
    w[0] = 32'h2008_0005; w[1] = 32'h8C09_0000; w[2] = 32'hAC09_0004;
    for (int i = 0; i < 3; i++) begin
      load_valid = 1; load_data = w[i];
      #1;
      checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL boot_we[%0d] got %b want 1", i, mem_we); end
      checks++; if (mem_addr !== i[ADDR_W-1:0]) begin errors++; $display("FAIL boot_addr[%0d] got %0d want %0d", i, mem_addr, i); end
      checks++; if (mem_wdata !== w[i]) begin errors++; $display("FAIL boot_wdata[%0d] got %h want %h", i, mem_wdata, w[i]); end
      checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL boot_ready[%0d] got %b want 1", i, load_ready); end
      @(posedge clk);
      ref_mem[i] = w[i];
      #1;
    end
    load_valid = 0; load_done = 1;
    @(posedge clk);
    m_pc = 32'h0;
    #1;
    load_done = 0;
    checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL boot_ready_run got %b want 0", load_ready); end
    checks++; if (mem_addr !== '0) begin errors++; $display("FAIL boot_first_addr got %0d want 0", mem_addr); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL boot_first_valid got %b want 0", if_valid); end
    for (int i = 0; i < 2; i++) begin
      cycle(0, 32'h0, 0);
      checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d] got %b want 1", i, if_valid); end
      checks++; if (if_pc !== 32'(i * 4)) begin errors++; $display("FAIL seq_pc[%0d] got %h want %h", i, if_pc, i * 4); end
      checks++; if (if_inst !== w[i]) begin errors++; $display("FAIL seq_inst[%0d] got %h want %h", i, if_inst, w[i]); end
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 2; i++) begin
      cycle(0, 32'h0, 1);
      checks++; if (if_pc !== 32'h4) begin errors++; $display("FAIL stall_pc[%0d] got %h want 4", i, if_pc); end
      checks++; if (if_inst !== 32'h8C09_0000) begin errors++; $display("FAIL stall_inst[%0d] got %h want 8c090000", i, if_inst); end
      checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got %b want 1", i, if_valid); end
    end
    cycle(0, 32'h0, 0);
    checks++; if (if_pc !== 32'h8) begin errors++; $display("FAIL stall_release_pc got %h want 8", if_pc); end
    checks++; if (if_inst !== 32'hAC09_0004) begin errors++; $display("FAIL stall_release_inst got %h want ac090004", if_inst); end
  endtask

  task automatic test_redirect();
    cycle(1, 32'h43, 1);
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL redir_bubble got %b want 0", if_valid); end
    checks++; if (if_pc !== 32'h8) begin errors++; $display("FAIL redir_pc_held got %h want 8", if_pc); end
    checks++; if (mem_addr !== 7'd16) begin errors++; $display("FAIL redir_addr got %0d want 16", mem_addr); end
    cycle(0, 32'h0, 0);
    checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL redir_valid got %b want 1", if_valid); end
    checks++; if (if_pc !== 32'h40) begin errors++; $display("FAIL redir_pc got %h want 40", if_pc); end
    checks++; if (if_inst !== ref_mem[16]) begin errors++; $display("FAIL redir_inst got %h want %h", if_inst, ref_mem[16]); end
  endtask

  task automatic test_random_run();
    bit r, s;
    logic [31:0] rpc;
    for (int i = 0; i < 300; i++) begin
      r   = ($urandom_range(0, 7) == 0) || (m_pc >= 32'h1F0);
      rpc = 32'(($urandom_range(0, DEPTH - 1) << 2) | $urandom_range(0, 3));
      s   = ($urandom_range(0, 3) == 0);
      cycle(r, rpc, s);
      checks++; if (if_valid !== m_valid) begin errors++; $display("FAIL rand_valid[%0d] got %b want %b", i, if_valid, m_valid); end
      checks++; if (if_pc !== m_ifpc) begin errors++; $display("FAIL rand_pc[%0d] got %h want %h", i, if_pc, m_ifpc); end
      checks++; if (if_inst !== m_inst) begin errors++; $display("FAIL rand_inst[%0d] got %h want %h", i, if_inst, m_inst); end
      checks++; if (mem_addr !== m_pc[ADDR_W+1:2]) begin errors++; $display("FAIL rand_addr[%0d] got %0d want %0d", i, mem_addr, m_pc / 4); end
      checks++; if (halted !== m_halted) begin errors++; $display("FAIL rand_halted[%0d] got %b want %b", i, halted, m_halted); end
    end
  endtask

  task automatic test_reset_midrun();
    reset = 1;
    #1;
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL mrst_valid got %b want 0", if_valid); end
    checks++; if (if_inst !== 32'h0) begin errors++; $display("FAIL mrst_inst got %h want 0", if_inst); end
    checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL mrst_pc got %h want 0", if_pc); end
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL mrst_ready got %b want 1", load_ready); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL mrst_we got %b want 0", mem_we); end
    @(posedge clk);
    #1;
    reset = 0;
    model_reset();
    @(posedge clk);
    #1;
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL mrst_boot_ready got %b want 1", load_ready); end
    load_done = 1;
    @(posedge clk);
    m_pc = 32'h0;
    #1;
    load_done = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(0, 32'h0, 0);
      checks++; if (if_pc !== m_ifpc) begin errors++; $display("FAIL mrst_fetch_pc[%0d] got %h want %h", i, if_pc, m_ifpc); end
      checks++; if (if_inst !== m_inst) begin errors++; $display("FAIL mrst_fetch_inst[%0d] got %h want %h", i, if_inst, m_inst); end
      checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL mrst_fetch_valid[%0d] got %b want 1", i, if_valid); end
    end
  endtask

  task automatic test_halt();
    logic [31:0] held_pc;
    cycle(1, 32'h200, 0);
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL halt_bubble got %b want 0", if_valid); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_early got %b want 0", halted); end
    held_pc = m_ifpc;
    cycle(0, 32'h0, 0);
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_set got %b want 1", halted); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL halt_valid got %b want 0", if_valid); end
    cycle(1, 32'h0, 0);
    load_valid = 1; load_data = 32'hDEAD_BEEF;
    cycle(0, 32'h0, 0);
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL halt_we got %b want 0", mem_we); end
    load_valid = 0;
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_sticky got %b want 1", halted); end
    checks++; if (if_valid !== m_valid) begin errors++; $display("FAIL halt_ignore_valid got %b want %b", if_valid, m_valid); end
    checks++; if (if_pc !== held_pc) begin errors++; $display("FAIL halt_pc_frozen got %h want %h", if_pc, held_pc); end
    checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL halt_ready got %b want 0", load_ready); end
  endtask

  task automatic test_full_load();
    logic [31:0] v;
    reset = 1;
    @(posedge clk);
    #1;
    reset = 0;
    model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      v = $urandom;
      load_valid = 1; load_data = v;
      #1;
      checks++; if (mem_we !== 1'b1 || mem_addr !== i[ADDR_W-1:0] || load_ready !== 1'b1) begin
        errors++; $display("FAIL full_write[%0d] got we=%b addr=%0d ready=%b want 1/%0d/1", i, mem_we, mem_addr, load_ready, i);
      end
      @(posedge clk);
      ref_mem[i] = v;
      #1;
    end
    m_pc = 32'h0;
    load_data = 32'h1234_5678;
    checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", load_ready); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL full_we_after got %b want 0", mem_we); end
    checks++; if (mem_addr !== '0) begin errors++; $display("FAIL full_addr got %0d want 0", mem_addr); end
    cycle(0, 32'h0, 0);
    load_valid = 0;
    checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL full_first_valid got %b want 1", if_valid); end
    checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL full_first_pc got %h want 0", if_pc); end
    checks++; if (if_inst !== ref_mem[0]) begin errors++; $display("FAIL full_first_inst got %h want %h", if_inst, ref_mem[0]); end
    cycle(1, 32'h1FC, 0);
    cycle(0, 32'h0, 0);
    checks++; if (if_pc !== 32'h1FC || if_inst !== ref_mem[DEPTH-1]) begin
      errors++; $display("FAIL full_last_word got %h/%h want 1fc/%h", if_pc, if_inst, ref_mem[DEPTH-1]);
    end
    cycle(0, 32'h0, 0);
    checks++; if (halted !== 1'b1 || if_valid !== 1'b0) begin
      errors++; $display("FAIL full_wrap_halt got halted=%b valid=%b want 1/0", halted, if_valid);
    end
  endtask

  initial begin
    logic [31:0] v;
    reset = 1; load_valid = 0; load_data = 0; load_done = 0;
    stall = 0; redirect = 0; redirect_pc = 0;
    for (int i = 0; i < DEPTH; i++) begin
      v = $urandom;
      mem[i] <= v;
      ref_mem[i] = v;
    end
    model_reset();
    test_reset();
    test_boot_seq();
    test_stall();
    test_redirect();
    test_random_run();
    test_reset_midrun();
    test_halt();
    test_full_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
